// File: rtl/s_mul_seq.sv
// Saber small-secret multiplier lane sequencer: negacyclic a*s in Z_8192[x]/(x^N+1),
// one product term per cycle read-modify-written into an external accumulator RAM.
module s_mul_seq #(
  parameter int N    = 256,
  parameter int LOGN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clr,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] s_addr,
  input  logic [3:0]      s_rdata,
  output logic [LOGN-1:0] a_addr,
  input  logic [12:0]     a_rdata,
  output logic [LOGN-1:0] acc_raddr,
  input  logic [12:0]     acc_rdata,
  output logic [LOGN-1:0] acc_waddr,
  output logic [12:0]     acc_wdata,
  output logic            acc_we
);

  // state | meaning
  // IDLE  | waiting for start
  // SREAD | s[j] address issued, no accumulator read this cycle
  // MAC   | a[i] and acc[(i+j) mod N] reads issued, i = 0..N-1
  // DRAIN | final write of the last row, done pulse
  typedef enum logic [1:0] {IDLE, SREAD, MAC, DRAIN} state_t;

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  state_t          state_q, state_d;
  logic [LOGN-1:0] i_q, i_d, j_q, j_d;
  logic [LOGN-1:0] wi_q, wi_d, wj_q, wj_d;
  logic [3:0]      s_reg_q, s_reg_d;
  logic            clr_q, clr_d;
  logic            wr_q, wr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    s_reg_d = s_reg_q;
    clr_d   = clr_q;
    wr_d    = (state_q == MAC);
    wi_d    = i_q;
    wj_d    = j_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr_d   = clr;
          i_d     = '0;
          j_d     = '0;
          state_d = SREAD;
        end
      end
      SREAD: begin
        i_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        if (i_q == '0) s_reg_d = s_rdata;
        i_d = i_q + 1'b1;
        if (i_q == LAST) begin
          if (j_q != LAST) begin
            j_d     = j_q + 1'b1;
            state_d = SREAD;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        i_d     = '0;
        j_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      wi_q    <= '0;
      wj_q    <= '0;
      s_reg_q <= '0;
      clr_q   <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      s_reg_q <= s_reg_d;
      clr_q   <= clr_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Write stage: operates on the indices of the MAC cycle that issued the reads.
  logic [LOGN:0] wsum;
  logic [12:0]   a2, a3, a4, mult, ri, wdata;
  logic          neg;

  assign wsum = {1'b0, wi_q} + {1'b0, wj_q};
  assign neg  = s_reg_q[3] ^ wsum[LOGN];

  always_comb begin
    a2 = {a_rdata[11:0], 1'b0};
    a4 = {a_rdata[10:0], 2'b00};
    a3 = a_rdata + a2;
    case (s_reg_q[2:0])
      3'd0:    mult = '0;
      3'd1:    mult = a_rdata;
      3'd2:    mult = a2;
      3'd3:    mult = a3;
      default: mult = a4;
    endcase
    ri    = (clr_q && (wj_q == '0)) ? '0 : acc_rdata;
    wdata = neg ? (ri - mult) : (ri + mult);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign s_addr    = j_q;
  assign a_addr    = i_q;
  assign acc_raddr = i_q + j_q;
  assign acc_waddr = wsum[LOGN-1:0];
  assign acc_we    = wr_q;
  assign acc_wdata = wr_q ? wdata : '0;

endmodule

// File: tb/tb_s_mul_seq.sv
// Bench for s_mul_seq: directed N=4 cases and a random N=256 run checked against
// a negacyclic schoolbook model, with results compared through scoreboard queues.
module tb_s_mul_seq;

  logic clk;
  logic rst_n;

  logic        start4, clr4, busy4, done4, acc_we4;
  logic [1:0]  s_addr4, a_addr4, acc_raddr4, acc_waddr4;
  logic [3:0]  s_rdata4;
  logic [12:0] a_rdata4, acc_rdata4, acc_wdata4;
  logic [12:0] a_mem4 [4];
  logic [12:0] acc_mem4 [4];
  logic [12:0] acc_init4 [4];
  logic [3:0]  s_mem4 [4];
  logic        ld4;

  logic        start256, clr256, busy256, done256, acc_we256;
  logic [7:0]  s_addr256, a_addr256, acc_raddr256, acc_waddr256;
  logic [3:0]  s_rdata256;
  logic [12:0] a_rdata256, acc_rdata256, acc_wdata256;
  logic [12:0] a_mem256 [256];
  logic [12:0] acc_mem256 [256];
  logic [12:0] acc_init256 [256];
  logic [3:0]  s_mem256 [256];
  logic        ld256;

  int n_checks;
  int n_fail;
  int q4[$];
  int q256[$];

  s_mul_seq #(.N(4), .LOGN(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .clr(clr4),
    .busy(busy4), .done(done4),
    .s_addr(s_addr4), .s_rdata(s_rdata4),
    .a_addr(a_addr4), .a_rdata(a_rdata4),
    .acc_raddr(acc_raddr4), .acc_rdata(acc_rdata4),
    .acc_waddr(acc_waddr4), .acc_wdata(acc_wdata4), .acc_we(acc_we4)
  );

  s_mul_seq #(.N(256), .LOGN(8)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .clr(clr256),
    .busy(busy256), .done(done256),
    .s_addr(s_addr256), .s_rdata(s_rdata256),
    .a_addr(a_addr256), .a_rdata(a_rdata256),
    .acc_raddr(acc_raddr256), .acc_rdata(acc_rdata256),
    .acc_waddr(acc_waddr256), .acc_wdata(acc_wdata256), .acc_we(acc_we256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models; ld* copies the preload image into the accumulator.
  always @(posedge clk) begin
    a_rdata4   <= a_mem4[a_addr4];
    s_rdata4   <= s_mem4[s_addr4];
    acc_rdata4 <= acc_mem4[acc_raddr4];
    if (ld4) acc_mem4 <= acc_init4;
    else if (acc_we4) acc_mem4[acc_waddr4] <= acc_wdata4;
    a_rdata256   <= a_mem256[a_addr256];
    s_rdata256   <= s_mem256[s_addr256];
    acc_rdata256 <= acc_mem256[acc_raddr256];
    if (ld256) acc_mem256 <= acc_init256;
    else if (acc_we256) acc_mem256[acc_waddr256] <= acc_wdata256;
  end

  task automatic push4(input int e0, input int e1, input int e2, input int e3);
    q4.push_back(e0); q4.push_back(e1); q4.push_back(e2); q4.push_back(e3);
  endtask

  task automatic run4(input logic c, input int ign_at, input string name);
    int cyc, dcyc, nwe, e;
    ld4 = 1'b1;
    @(negedge clk);
    ld4 = 1'b0;
    start4 = 1'b1;
    clr4 = c;
    cyc = 0; dcyc = -1; nwe = 0;
    while (cyc < 40 && dcyc < 0) begin
      @(negedge clk);
      cyc++;
      start4 = (cyc == ign_at);
      if (cyc == 1) begin
        n_checks++;
        if (busy4 !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy_at_cycle1: got %b expected 1", name, busy4);
        end
      end
      if (acc_we4 === 1'b1) nwe++;
      if (done4 === 1'b1) dcyc = cyc;
    end
    start4 = 1'b0;
    n_checks++;
    if (dcyc != 21) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d expected 21", name, dcyc);
    end
    n_checks++;
    if (nwe != 16) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d expected 16", name, nwe);
    end
    @(negedge clk);
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || acc_we4 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_done: got busy=%b done=%b we=%b expected 0 0 0",
               name, busy4, done4, acc_we4);
    end
    for (int k = 0; k < 4; k++) begin
      e = q4.pop_front();
      n_checks++;
      if (int'(acc_mem4[k]) !== e) begin
        n_fail++;
        $display("FAIL %s coef%0d: got %0d expected %0d", name, k, acc_mem4[k], e);
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || acc_we4 !== 1'b0 || busy256 !== 1'b0 ||
        acc_we256 !== 1'b0 || done256 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got busy4=%b done4=%b we4=%b busy256=%b we256=%b expected all 0",
               busy4, done4, acc_we4, busy256, acc_we256);
    end
    n_checks++;
    if (s_addr4 !== 2'd0 || a_addr4 !== 2'd0 || acc_raddr4 !== 2'd0 ||
        acc_waddr4 !== 2'd0 || acc_wdata4 !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got s=%0d a=%0d r=%0d w=%0d wd=%0d expected all 0",
               s_addr4, a_addr4, acc_raddr4, acc_waddr4, acc_wdata4);
    end
  endtask

  task automatic test_identity;
    a_mem4 = '{13'd1, 13'd2, 13'd3, 13'd4};
    s_mem4 = '{4'd1, 4'd0, 4'd0, 4'd0};
    acc_init4 = '{13'd77, 13'd88, 13'd99, 13'd111};
    push4(1, 2, 3, 4);
    run4(1'b1, 0, "identity");
  endtask

  task automatic test_negacyclic_wrap;
    a_mem4 = '{13'd1, 13'd2, 13'd3, 13'd4};
    s_mem4 = '{4'd0, 4'd1, 4'd0, 4'd0};
    acc_init4 = '{13'd5, 13'd6, 13'd7, 13'd8};
    push4(8188, 1, 2, 3);
    run4(1'b1, 0, "wrap");
  endtask

  task automatic test_neg_max;
    a_mem4 = '{13'd100, 13'd0, 13'd0, 13'd0};
    s_mem4 = '{4'hC, 4'd0, 4'd0, 4'd0};
    acc_init4 = '{13'd1, 13'd2, 13'd3, 13'd4};
    push4(7792, 0, 0, 0);
    run4(1'b1, 0, "neg4");
    s_mem4 = '{4'hF, 4'd0, 4'd0, 4'd0};
    push4(7792, 0, 0, 0);
    run4(1'b1, 0, "neg7");
  endtask

  task automatic test_accumulate;
    a_mem4 = '{13'd1, 13'd1, 13'd1, 13'd1};
    s_mem4 = '{4'd2, 4'd0, 4'd0, 4'd0};
    acc_init4 = '{13'd10, 13'd20, 13'd30, 13'd40};
    push4(12, 22, 32, 42);
    run4(1'b0, 0, "accumulate");
    a_mem4 = '{13'd1, 13'd0, 13'd0, 13'd0};
    s_mem4 = '{4'd1, 4'd0, 4'd0, 4'd0};
    acc_init4 = '{13'd8191, 13'd8191, 13'd8191, 13'd8191};
    push4(0, 8191, 8191, 8191);
    run4(1'b0, 0, "acc_wrap");
  endtask

  task automatic test_start_while_busy;
    a_mem4 = '{13'd5, 13'd6, 13'd7, 13'd8};
    s_mem4 = '{4'd3, 4'd0, 4'd0, 4'd0};
    acc_init4 = '{13'd0, 13'd0, 13'd0, 13'd0};
    push4(15, 18, 21, 24);
    run4(1'b1, 5, "start_busy");
  endtask

  task automatic test_reset_midrun;
    int cyc;
    a_mem4 = '{13'd1, 13'd2, 13'd3, 13'd4};
    s_mem4 = '{4'd1, 4'd0, 4'd0, 4'd0};
    acc_init4 = '{13'd555, 13'd555, 13'd555, 13'd555};
    ld4 = 1'b1;
    @(negedge clk);
    ld4 = 1'b0;
    start4 = 1'b1;
    clr4 = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
    end
    n_checks++;
    if (busy4 !== 1'b1 || acc_we4 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_active: got busy=%b we=%b expected 1 1", busy4, acc_we4);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy4 !== 1'b0 || acc_we4 !== 1'b0 || done4 !== 1'b0 || a_addr4 !== 2'd0 ||
        acc_waddr4 !== 2'd0 || acc_wdata4 !== 13'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b we=%b done=%b a=%0d w=%0d wd=%0d expected all 0",
               busy4, acc_we4, done4, a_addr4, acc_waddr4, acc_wdata4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push4(1, 2, 3, 4);
    run4(1'b1, 0, "after_reset");
  endtask

  task automatic test_random;
    int ex [256];
    int m, k, term, cyc, dcyc, nwe, e;
    logic sg;
    for (int i = 0; i < 256; i++) begin
      a_mem256[i] = 13'($urandom_range(0, 8191));
      m = $urandom_range(0, 4);
      sg = 1'($urandom_range(0, 1));
      s_mem256[i] = {sg, 3'(m)};
      acc_init256[i] = 13'($urandom_range(0, 8191));
      ex[i] = 0;
    end
    for (int j = 0; j < 256; j++) begin
      m = int'(s_mem256[j][2:0]);
      if (m > 4) m = 4;
      for (int i = 0; i < 256; i++) begin
        term = int'(a_mem256[i]) * m;
        k = (i + j) % 256;
        if (s_mem256[j][3] ^ (i + j >= 256)) ex[k] = ex[k] - term;
        else ex[k] = ex[k] + term;
      end
    end
    for (int i = 0; i < 256; i++) q256.push_back(((ex[i] % 8192) + 8192) % 8192);
    ld256 = 1'b1;
    @(negedge clk);
    ld256 = 1'b0;
    start256 = 1'b1;
    clr256 = 1'b1;
    cyc = 0; dcyc = -1; nwe = 0;
    while (cyc < 66000 && dcyc < 0) begin
      @(negedge clk);
      cyc++;
      start256 = 1'b0;
      if (acc_we256 === 1'b1) nwe++;
      if (done256 === 1'b1) dcyc = cyc;
    end
    n_checks++;
    if (dcyc != 65793) begin
      n_fail++;
      $display("FAIL random done_cycle: got %0d expected 65793", dcyc);
    end
    n_checks++;
    if (nwe != 65536) begin
      n_fail++;
      $display("FAIL random write_count: got %0d expected 65536", nwe);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      e = q256.pop_front();
      n_checks++;
      if (int'(acc_mem256[i]) !== e) begin
        n_fail++;
        $display("FAIL random coef%0d: got %0d expected %0d", i, acc_mem256[i], e);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    start4 = 1'b0; clr4 = 1'b0; ld4 = 1'b0;
    start256 = 1'b0; clr256 = 1'b0; ld256 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_mem4[i] = '0; s_mem4[i] = '0; acc_init4[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      a_mem256[i] = '0; s_mem256[i] = '0; acc_init256[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_identity();
    test_negacyclic_wrap();
    test_neg_max();
    test_accumulate();
    test_start_while_busy();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s_mul_seq.md
# s_mul_seq

Sequencer for the Saber small-secret multiplier lane. It computes the negacyclic product of a public polynomial a (N coefficients, 13 bit) and a small secret polynomial s (N coefficients, 4-bit sign-magnitude, range −4..4) in Z_8192[x]/(x^N+1). Each product term is accumulated into an external accumulator RAM. It drives the a-, s- and accumulator-memory ports, and it contains one small-multiply ALU lane (add/subtract of 0, a, 2a, 3a or 4a) as its datapath.

## Interface
- N, 256: number of coefficients; power of two, at least 4.
- LOGN, 8: log2(N); address width.

- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a multiply; sampled only in IDLE.
- clr, input, 1: sampled with start; 1 = overwrite the accumulator, 0 = add into the existing contents.
- busy, output, 1: high while a multiply is in progress.
- done, output, 1: one-cycle pulse when the final write has been issued.
- s_addr, output, LOGN: s RAM read address.
- s_rdata, input, 4: s RAM data, valid 1 cycle after the address; bit 3 is the sign, bits 2:0 the magnitude.
- a_addr, output, LOGN: a RAM read address.
- a_rdata, input, 13: a RAM data, 1-cycle read latency.
- acc_raddr, output, LOGN: accumulator read address.
- acc_rdata, input, 13: accumulator data, 1-cycle read latency.
- acc_waddr, output, LOGN: accumulator write address.
- acc_wdata, output, 13: accumulator write data.
- acc_we, output, 1: accumulator write enable.

## Operation
- **States:** IDLE, SREAD, MAC, DRAIN.
- **Loop order:** outer counter j = 0..N−1 runs over s; inner counter i = 0..N−1 runs over a. Target index k = (i+j) mod N, computed with LOGN-bit wrap-around.
- **IDLE:**
  - start=1 → latch clr, set j=0, go to SREAD.
  - start=0 → stay in IDLE.
- **SREAD (1 cycle):** drive s_addr=j, set i=0, go to MAC.
- **MAC (N cycles, i = 0..N−1):**
  - Drive a_addr=i and acc_raddr=k.
  - In the first MAC cycle of a row, capture s_rdata into s_reg.
  - When i=N−1: if j<N−1, increment j and go to SREAD; otherwise go to DRAIN.
- **Write stage (every cycle following a MAC cycle):**
  - Ri = acc_rdata, or 0 when the latched clr=1 and j=0.
  - mag = s_reg[2:0]; the multiple is 0, a, 2a, 3a or 4a for mag 0..4; mag 5..7 is treated as 4.
  - 2a = a<<1, 4a = a<<2, 3a = a+2a; all truncated to 13 bits.
  - neg = s_reg[3] XOR (i+j ≥ N), using the delayed i and j of the issuing cycle.
  - acc_wdata = neg ? Ri − multiple : Ri + multiple, mod 2^13.
  - acc_waddr = the delayed k; acc_we = 1.
- **DRAIN (1 cycle):** performs the final write stage, pulses done, returns to IDLE.
- **Constant time:** rows with s = 0 or −0 are still executed in full. Timing never depends on data.
- **No hazards:**
  - Within a row every k is distinct.
  - The last write of row j (k=j−1 mod N) lands during the SREAD of row j+1, which issues no accumulator read.
- **clr=1 handling:** row 0 writes every k exactly once, so the accumulator ends up holding exactly a·s.
- **start while busy:** ignored.
- **Reset, at any time:**
  - Go to IDLE with all counters 0.
  - busy=0, done=0, acc_we=0, all addresses 0, acc_wdata=0.
  - Accumulator contents are left partial; this is not an error.

## Timing
- start is sampled at edge E0. busy=1 from the cycle after E0 through the done cycle inclusive.
- Each row takes 1 SREAD cycle plus N MAC cycles, so DRAIN is cycle N·(N+1)+1 after E0. done=1 in that cycle.
- A new start is accepted on the edge that ends the done cycle' successor (IDLE). Minimum start-to-start spacing is N·(N+1)+2 cycles.
- acc_we is high for exactly N² cycles per multiply and never in IDLE or SREAD without a pending write.
- All outputs are registered or decoded from registered state; none depends combinationally on start.

## Test plan
- **Identity:** N=4, a=[1,2,3,4], s=[1,0,0,0], clr=1 → acc=[1,2,3,4]; done at cycle 21 after start; 16 writes.
- **Negacyclic wrap:** N=4, a=[1,2,3,4], s=[0,1,0,0] (i.e. x), clr=1 → acc=[8188,1,2,3].
- **Negative maximum magnitude:** a=[100,0,0,0], s=[0xC,0,0,0] (−4), clr=1 → acc=[7792,0,0,0]. Repeat with s=[0xF,…] → same result (mag 7 treated as 4).
- **Accumulate:** clr=0, acc preloaded [10,20,30,40], a=[1,1,1,1], s=[2,0,0,0] → acc=[12,22,32,42]. Wrap check: preload acc=[8191,…], a=[1,…], s=[1,…] → coefficient 0 becomes 0 mod 8192.
- **Reset and start while busy:**
  - Pulse start at cycle 5 of a run → ignored; done still at cycle 21.
  - Assert rst_n=0 at cycle 10 → busy, acc_we and done drop immediately.
  - Release reset and start again → result is correct (clr=1).
- **Random regression:** N=256, random a and s in −4..4, clr=1 → acc matches the negacyclic schoolbook model mod 8192; done at cycle 65793.
